// File: rtl/stream_gen_pkg.sv
// Shared defaults and FSM encoding for the stream pattern generator.
package stream_gen_pkg;

    localparam int DEFAULT_DEPTH    = 8;
    localparam int DEFAULT_SAMPLE_W = 16;
    localparam int DEFAULT_LEN_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/stream_pattern_gen_if.sv
// Segment-table bus: one write port from the configuration side, one
// combinational read port used by the player.
interface stream_pattern_gen_if #(
    parameter int ADDR_W   = 3,
    parameter int SAMPLE_W = 16,
    parameter int LEN_W    = 8
);
    logic                       we;
    logic [ADDR_W-1:0]          wr_addr;
    logic signed [SAMPLE_W-1:0] wr_value;
    logic [LEN_W-1:0]           wr_length;
    logic [ADDR_W-1:0]          rd_addr;
    logic signed [SAMPLE_W-1:0] rd_value;
    logic [LEN_W-1:0]           rd_length;

    modport master (
        output we, wr_addr, wr_value, wr_length, rd_addr,
        input  rd_value, rd_length
    );

    modport slave (
        input  we, wr_addr, wr_value, wr_length, rd_addr,
        output rd_value, rd_length
    );
endinterface

// File: rtl/segment_table.sv
// Segment table: synchronous write, combinational read, synchronous clear.
module segment_table
    import stream_gen_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int LEN_W    = DEFAULT_LEN_W
) (
    input  logic                 clock,
    input  logic                 reset,
    stream_pattern_gen_if.slave  tbl
);
    logic signed [SAMPLE_W-1:0] value_mem  [DEPTH];
    logic [LEN_W-1:0]           length_mem [DEPTH];

    // NOTE: every entry is cleared on reset, so this maps to flops rather than
    // a RAM macro; that is intended for a table this small.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                value_mem[i]  <= '0;
                length_mem[i] <= '0;
            end
        end else if (tbl.we) begin
            value_mem[tbl.wr_addr]  <= tbl.wr_value;
            length_mem[tbl.wr_addr] <= tbl.wr_length;
        end
    end

    assign tbl.rd_value  = value_mem[tbl.rd_addr];
    assign tbl.rd_length = length_mem[tbl.rd_addr];

endmodule

// File: rtl/stream_pattern_gen.sv
// Plays a programmable sequence of (value, hold-length) segments as a
// registered sample stream, optionally looping, with stop and done handling.
module stream_pattern_gen
    import stream_gen_pkg::*;
#(
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int  LEN_W    = DEFAULT_LEN_W,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NSEG_W   = ADDR_W + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cfgWe,
    input  logic [ADDR_W-1:0]          cfgAddr,
    input  logic signed [SAMPLE_W-1:0] cfgValue,
    input  logic [LEN_W-1:0]           cfgLength,
    input  logic [NSEG_W-1:0]          numSegments,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic signed [SAMPLE_W-1:0] stream,
    output logic                       streamValid,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          segIndex
);
    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          seg_q, seg_d;
    logic [LEN_W-1:0]           hold_q, hold_d;
    logic [NSEG_W-1:0]          nseg_q, nseg_d;
    logic                       loop_q, loop_d;
    logic signed [SAMPLE_W-1:0] stream_q, stream_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       last_seg;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       bypass;
    logic signed [SAMPLE_W-1:0] entry_value;
    logic [LEN_W-1:0]           entry_length;
    logic [LEN_W-1:0]           hold_load;
    logic                       empty_req;

    stream_pattern_gen_if #(
        .ADDR_W  (ADDR_W),
        .SAMPLE_W(SAMPLE_W),
        .LEN_W   (LEN_W)
    ) tbl ();

    segment_table #(
        .DEPTH   (DEPTH),
        .SAMPLE_W(SAMPLE_W),
        .LEN_W   (LEN_W)
    ) u_table (
        .clock(clock),
        .reset(reset),
        .tbl  (tbl)
    );

    assign tbl.we        = cfgWe && (state_q == IDLE);
    assign tbl.wr_addr   = cfgAddr;
    assign tbl.wr_value  = cfgValue;
    assign tbl.wr_length = cfgLength;
    assign tbl.rd_addr   = rd_addr;

    assign last_seg = ({1'b0, seg_q} == (nseg_q - NSEG_W'(1)));
    assign rd_addr  = (state_q == PLAY && !last_seg) ? seg_q + ADDR_W'(1) : '0;

    // A write landing in the same cycle as start must be seen by the first sample.
    assign bypass       = tbl.we && (cfgAddr == rd_addr);
    assign entry_value  = bypass ? cfgValue  : tbl.rd_value;
    assign entry_length = bypass ? cfgLength : tbl.rd_length;
    assign hold_load    = (entry_length == '0) ? '0 : entry_length - LEN_W'(1);
    assign empty_req    = (numSegments == '0) || (numSegments > NSEG_W'(DEPTH));

    // NOTE: every variable gets its default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        hold_d   = hold_q;
        nseg_d   = nseg_q;
        loop_d   = loop_q;
        stream_d = stream_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                stream_d = '0;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                seg_d    = '0;
                hold_d   = '0;
                if (start && !stop) begin
                    if (empty_req) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = PLAY;
                        nseg_d   = numSegments;
                        loop_d   = loop;
                        stream_d = entry_value;
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                        hold_d   = hold_load;
                    end
                end
            end
            PLAY: begin
                if (stop || (hold_q == '0 && last_seg && !loop_q)) begin
                    state_d  = FINISH;
                    stream_d = '0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b0;
                    seg_d    = '0;
                    hold_d   = '0;
                    done_d   = 1'b1;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - LEN_W'(1);
                end else begin
                    seg_d    = rd_addr;
                    stream_d = entry_value;
                    hold_d   = hold_load;
                end
            end
            FINISH: begin
                state_d  = IDLE;
                stream_d = '0;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                seg_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            seg_q    <= '0;
            hold_q   <= '0;
            nseg_q   <= '0;
            loop_q   <= 1'b0;
            stream_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            hold_q   <= hold_d;
            nseg_q   <= nseg_d;
            loop_q   <= loop_d;
            stream_q <= stream_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stream      = stream_q;
    assign streamValid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign segIndex    = seg_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench for stream_pattern_gen; inputs change on the falling edge,
// outputs are compared on the falling edge after each rising edge.
module tb_stream_pattern_gen;
    import stream_gen_pkg::*;

    logic                clock;
    logic                reset;
    logic [3:0]          numSegments;
    logic                loop;
    logic                start;
    logic                stop;
    logic signed [15:0]  stream;
    logic                streamValid;
    logic                busy;
    logic                done;
    logic [2:0]          segIndex;

    int checks = 0;
    int errors = 0;

    stream_pattern_gen_if #(.ADDR_W(3), .SAMPLE_W(16), .LEN_W(8)) cfg_bus ();

    stream_pattern_gen dut (
        .clock      (clock),
        .reset      (reset),
        .cfgWe      (cfg_bus.we),
        .cfgAddr    (cfg_bus.wr_addr),
        .cfgValue   (cfg_bus.wr_value),
        .cfgLength  (cfg_bus.wr_length),
        .numSegments(numSegments),
        .loop       (loop),
        .start      (start),
        .stop       (stop),
        .stream     (stream),
        .streamValid(streamValid),
        .busy       (busy),
        .done       (done),
        .segIndex   (segIndex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic write_entry(input int addr, input int value, input int len);
        cfg_bus.we        = 1'b1;
        cfg_bus.wr_addr   = 3'(addr);
        cfg_bus.wr_value  = 16'(value);
        cfg_bus.wr_length = 8'(len);
        @(negedge clock);
        cfg_bus.we = 1'b0;
    endtask

    task automatic pulse_start(input int nseg, input logic lp);
        numSegments = 4'(nseg);
        loop        = lp;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({stream, streamValid, busy, done, segIndex} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: stream=%0d valid=%b busy=%b done=%b seg=%0d, expected all 0",
                     stream, streamValid, busy, done, segIndex);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_sequence();
        logic signed [15:0] exp_v;
        write_entry(0, 1, 19);
        write_entry(1, 5, 1);
        write_entry(2, 15, 1);
        write_entry(3, -5, 1);
        pulse_start(4, 1'b0);
        for (int i = 0; i < 22; i++) begin
            exp_v = (i < 19) ? 16'sd1 : (i == 19) ? 16'sd5 : (i == 20) ? 16'sd15 : -16'sd5;
            checks++;
            if (stream !== exp_v || streamValid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL seq_sample[%0d]: stream=%0d valid=%b busy=%b, expected %0d 1 1",
                         i, stream, streamValid, busy, exp_v);
            end
            @(negedge clock);
        end
        checks++;
        if (done !== 1'b1 || streamValid !== 1'b0 || stream !== 16'sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_done: done=%b valid=%b stream=%0d busy=%b, expected 1 0 0 0",
                     done, streamValid, stream, busy);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_done_width: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_loop_stop();
        logic signed [15:0] exp_v;
        write_entry(0, 20, 20);
        write_entry(1, 0, 3);
        pulse_start(2, 1'b1);
        for (int i = 0; i < 30; i++) begin
            exp_v = ((i % 23) < 20) ? 16'sd20 : 16'sd0;
            checks++;
            if (stream !== exp_v || streamValid !== 1'b1) begin
                errors++;
                $display("FAIL loop_sample[%0d]: stream=%0d valid=%b, expected %0d 1",
                         i, stream, streamValid, exp_v);
            end
            if (i < 29) @(negedge clock);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        checks++;
        if (done !== 1'b1 || streamValid !== 1'b0 || stream !== 16'sd0) begin
            errors++;
            $display("FAIL loop_stop_done: done=%b valid=%b stream=%0d, expected 1 0 0",
                     done, streamValid, stream);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop_idle: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_zero_length_same_cycle_write();
        // Entry 0 still holds 20 here; the same-cycle write must replace it.
        cfg_bus.we        = 1'b1;
        cfg_bus.wr_addr   = 3'd0;
        cfg_bus.wr_value  = 16'sd18;
        cfg_bus.wr_length = 8'd0;
        pulse_start(1, 1'b0);
        cfg_bus.we = 1'b0;
        checks++;
        if (stream !== 16'sd18 || streamValid !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_sample: stream=%0d valid=%b, expected 18 1", stream, streamValid);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || streamValid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b valid=%b, expected 1 0", done, streamValid);
        end
    endtask

    task automatic test_empty();
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            pulse_start((k == 0) ? 0 : 9, 1'b0);
            checks++;
            if (done !== 1'b1 || streamValid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_done[%0d]: done=%b valid=%b busy=%b, expected 1 0 0",
                         k, done, streamValid, busy);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || streamValid !== 1'b0) begin
                errors++;
                $display("FAIL empty_after[%0d]: done=%b valid=%b, expected 0 0", k, done, streamValid);
            end
        end
    endtask

    task automatic test_write_in_play_and_reset();
        logic signed [15:0] exp_v;
        @(negedge clock);
        write_entry(0, 7, 2);
        write_entry(1, -3, 2);
        pulse_start(2, 1'b0);
        cfg_bus.we        = 1'b1;
        cfg_bus.wr_addr   = 3'd1;
        cfg_bus.wr_value  = 16'sd99;
        cfg_bus.wr_length = 8'd2;
        for (int i = 0; i < 4; i++) begin
            exp_v = (i < 2) ? 16'sd7 : -16'sd3;
            checks++;
            if (stream !== exp_v || segIndex !== 3'(i / 2)) begin
                errors++;
                $display("FAIL busy_write_sample[%0d]: stream=%0d seg=%0d, expected %0d %0d",
                         i, stream, segIndex, exp_v, i / 2);
            end
            @(negedge clock);
            cfg_bus.we = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_done: done=%b, expected 1", done);
        end
        @(negedge clock);
        pulse_start(2, 1'b1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({stream, streamValid, busy, done, segIndex} !== 22'd0) begin
            errors++;
            $display("FAIL midplay_reset: stream=%0d valid=%b busy=%b done=%b seg=%0d, expected all 0",
                     stream, streamValid, busy, done, segIndex);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midplay_reset_after: done=%b busy=%b, expected 0 0", done, busy);
        end
        // Reset must have cleared entry 0 to value 0 / length 0.
        pulse_start(1, 1'b0);
        checks++;
        if (stream !== 16'sd0 || streamValid !== 1'b1) begin
            errors++;
            $display("FAIL table_cleared: stream=%0d valid=%b, expected 0 1", stream, streamValid);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL table_cleared_done: done=%b, expected 1", done);
        end
        @(negedge clock);
    endtask

    task automatic test_start_stop_together();
        stop = 1'b1;
        pulse_start(1, 1'b0);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || streamValid !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%b done=%b valid=%b, expected 0 0 0",
                     busy, done, streamValid);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_next: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    initial begin
        reset             = 1'b1;
        numSegments       = '0;
        loop              = 1'b0;
        start             = 1'b0;
        stop              = 1'b0;
        cfg_bus.we        = 1'b0;
        cfg_bus.wr_addr   = '0;
        cfg_bus.wr_value  = '0;
        cfg_bus.wr_length = '0;
        cfg_bus.rd_addr   = '0;
        @(negedge clock);
        test_reset();
        test_sequence();
        test_loop_stop();
        test_zero_length_same_cycle_write();
        test_empty();
        test_write_in_play_and_reset();
        test_start_stop_together();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
